// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register indices, stage control bits,
// mul/div handshake, and the forwarding/stall/flush/counter outputs.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       RS1_D, RS2_D;
    logic [4:0]       RS1_E, RS2_E, RD_E;
    logic [4:0]       RD_M, RD_W;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MulDivE;
    logic             MD_done;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardA_D, ForwardB_D;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE;
    logic             BubbleM;
    logic             MD_start;
    logic             md_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MD_done,
        input  ForwardAE, ForwardBE, ForwardA_D, ForwardB_D,
               StallF, StallD, StallE, FlushD, FlushE, BubbleM, MD_start,
               md_error, stall_count, flush_count
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MD_done,
        output ForwardAE, ForwardBE, ForwardA_D, ForwardB_D,
               StallF, StallD, StallE, FlushD, FlushE, BubbleM, MD_start,
               md_error, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 core: forwarding selects, load-use
// stall, branch flush, mul/div sequencing with timeout, and debug counters.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int unsigned      CW       = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    md_state_e        state_q;
    logic [CW-1:0]    md_cnt_q;
    logic             md_error_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic md_last, md_release, md_timeout, md_hold, md_start;
    logic load_use, lu_stall;
    logic stall_f, flush_d;

    function automatic logic match(input logic [4:0] rx, input logic we,
                                   input logic [4:0] ry);
        return we && (rx != 5'd0) && (rx == ry);
    endfunction

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (match(hz.RD_M, hz.RegWriteM, hz.RS1_E))      hz.ForwardAE = 2'b10;
        else if (match(hz.RD_W, hz.RegWriteW, hz.RS1_E)) hz.ForwardAE = 2'b01;

        hz.ForwardBE = 2'b00;
        if (match(hz.RD_M, hz.RegWriteM, hz.RS2_E))      hz.ForwardBE = 2'b10;
        else if (match(hz.RD_W, hz.RegWriteW, hz.RS2_E)) hz.ForwardBE = 2'b01;

        hz.ForwardA_D = match(hz.RD_W, hz.RegWriteW, hz.RS1_D);
        hz.ForwardB_D = match(hz.RD_W, hz.RegWriteW, hz.RS2_D);
    end

    // Mul/div hold terms are gated by reset so an asynchronous reset mid-BUSY
    // drops the stalls immediately, even if MulDivE is still asserted.
    always_comb begin
        md_last    = (state_q == MD_BUSY) && (md_cnt_q == CNT_LAST);
        md_release = (state_q == MD_BUSY) && (hz.MD_done || md_last);
        md_timeout = md_last && !hz.MD_done;
        md_start   = reset && (state_q == MD_IDLE) && hz.MulDivE;
        md_hold    = md_start || (reset && (state_q == MD_BUSY) && !md_release);

        load_use = (hz.ResultSrcE == 2'b01) && (hz.RD_E != 5'd0) &&
                   ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
        lu_stall = load_use && !hz.PCSrcE && !md_hold;

        stall_f = md_hold || lu_stall;
        flush_d = hz.PCSrcE;

        hz.StallF   = stall_f;
        hz.StallD   = stall_f;
        hz.StallE   = md_hold;
        hz.FlushD   = flush_d;
        hz.FlushE   = (hz.PCSrcE || lu_stall) && !md_hold;
        hz.BubbleM  = md_hold;
        hz.MD_start = md_start;

        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MD_IDLE;
            md_cnt_q    <= '0;
            md_error_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                MD_IDLE: begin
                    if (hz.MulDivE) begin
                        state_q  <= MD_BUSY;
                        md_cnt_q <= '0;
                    end
                end
                MD_BUSY: begin
                    if (md_release) begin
                        state_q <= MD_IDLE;
                        if (md_timeout) md_error_q <= 1'b1;
                    end else begin
                        md_cnt_q <= md_cnt_q + CW'(1);
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign hz.md_error    = md_error_q;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule
